data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the pipeline's memory stage and data_mem_responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with configurable wait states and a one-cycle response strobe.
// DMEM_SUBWORD_EN enables byte/halfword accesses with alignment checks; otherwise every access is a full word.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } req_t;

  state_t         state, state_d;
  logic [3:0]     cnt, cnt_d;
  req_t           rq, cur;
  logic           accept, enter_resp, wr_en, acc_err, err_q;
  logic [31:0]    ld_val, rdata_q;
  logic [1:0]     off;
  logic [AW-1:0]  idx;
  logic [3:0]     wmask;
  logic [3:0][7:0] wlanes, rd_word;
  logic [3:0][7:0] mem [DEPTH];

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) state_d = RESP;
        else begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = RESP;
        else cnt_d = cnt - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accept edge itself, so the live bus is used.
  always_comb begin
    cur = rq;
    if (state == IDLE) cur = '{we: bus.req_we, addr: bus.req_addr,
                               wdata: bus.req_wdata, funct3: bus.req_funct3};
  end

  assign enter_resp = (state != RESP) && (state_d == RESP);
  assign idx        = cur.addr[AW+1:2];
  assign off        = cur.addr[1:0];
  assign rd_word    = mem[idx];

`ifdef DMEM_SUBWORD_EN
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  assign rd_byte = rd_word[off];
  assign rd_half = off[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};

  always_comb begin
    acc_err = 1'b0;
    wmask   = 4'b0000;
    wlanes  = cur.wdata;
    ld_val  = rd_word;
    unique case (cur.funct3)
      3'b000: begin
        wmask  = 4'b0001 << off;
        wlanes = {4{cur.wdata[7:0]}};
        ld_val = {{24{rd_byte[7]}}, rd_byte};
      end
      3'b001: begin
        acc_err = off[0];
        wmask   = off[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{cur.wdata[15:0]}};
        ld_val  = {{16{rd_half[15]}}, rd_half};
      end
      3'b010: begin
        acc_err = (off != 2'b00);
        wmask   = 4'b1111;
      end
      3'b100: begin
        acc_err = cur.we;
        ld_val  = {24'd0, rd_byte};
      end
      3'b101: begin
        acc_err = cur.we | off[0];
        ld_val  = {16'd0, rd_half};
      end
      default: acc_err = 1'b1;
    endcase
    if (acc_err) begin
      wmask  = 4'b0000;
      ld_val = 32'd0;
    end
    if (cur.we) ld_val = 32'd0;
  end

  logic unused_ok;
  assign unused_ok = ^cur.addr[31:AW+2];
`else
  always_comb begin
    acc_err = 1'b0;
    wmask   = 4'b1111;
    wlanes  = cur.wdata;
    ld_val  = cur.we ? 32'd0 : rd_word;
  end

  logic unused_ok;
  assign unused_ok = ^{cur.addr[31:AW+2], off, cur.funct3};
`endif

  assign wr_en = !reset && enter_resp && cur.we && !acc_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) rq <= cur;
      if (enter_resp) begin
        rdata_q <= ld_val;
        err_q   <= acc_err;
      end
    end
  end

  // Memory is never reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_en && wmask[i]) mem[idx][i] <= wlanes[i];
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.busy       = (state != IDLE);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses are queued at accept and checked on resp_valid.
module tb_data_mem_responder;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0, n_bad = 0, cyc = 0;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.resp_valid === 1'b1) begin
      chk("resp_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
        chk("resp_latency", 32'(cyc + 1 - e.acc), 32'(W + 1));
      end
    end
  end

  task automatic idle_bus();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_funct3 = 3'b010;
  endtask

  // Issue one request from a negedge; abort pulses reset during the first wait cycle.
  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                     input bit abort);
    int t = 0;
    exp_t e;
    while (bus.req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_req", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    @(posedge clk);
    #1;
    if (!abort) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.acc   = cyc;
      sb.push_back(e);
      // Junk store to word 0x10 held while busy; it must be ignored.
      bus.req_we     = 1'b1;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'hBAD0BAD0;
      bus.req_funct3 = 3'b010;
    end else idle_bus();
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (abort) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rdata", bus.resp_rdata, 32'd0);
        break;
      end
      chk("busy_ready_low", 32'(bus.req_ready), 32'd0);
      chk("busy_high", 32'(bus.busy), 32'd1);
    end
    idle_bus();
    @(negedge clk);
    chk("ready_after_resp", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle_bus();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err", 32'(bus.resp_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    req(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0, 0);
    req(0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0, 0);
    req(1, 32'h400, 32'h12345678, 3'b010, 32'h0, 0, 0);
    req(0, 32'h0, 32'h0, 3'b010, 32'h12345678, 0, 0);

    req(1, 32'h30, 32'h55555555, 3'b010, 32'h0, 0, 0);
    req(1, 32'h30, 32'hAAAAAAAA, 3'b010, 32'h0, 0, 1);
    // Reset coinciding with a valid request drops it.
    reset = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'h77777777;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_bus();
    @(negedge clk);
    chk("coincide_busy", 32'(bus.busy), 32'd0);
    chk("coincide_ready", 32'(bus.req_ready), 32'd1);
    req(0, 32'h30, 32'h0, 3'b010, 32'h55555555, 0, 0);

`ifdef DMEM_SUBWORD_EN
    req(1, 32'h20, 32'h0, 3'b010, 32'h0, 0, 0);
    req(1, 32'h21, 32'h80, 3'b000, 32'h0, 0, 0);
    req(0, 32'h20, 32'h0, 3'b010, 32'h00008000, 0, 0);
    req(0, 32'h21, 32'h0, 3'b000, 32'hFFFFFF80, 0, 0);
    req(0, 32'h21, 32'h0, 3'b100, 32'h00000080, 0, 0);
    req(0, 32'h13, 32'h0, 3'b001, 32'h0, 1, 0);
    req(0, 32'h12, 32'h0, 3'b010, 32'h0, 1, 0);
    req(0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0, 0);
    req(1, 32'h22, 32'h1234BEEF, 3'b001, 32'h0, 0, 0);
    req(0, 32'h20, 32'h0, 3'b010, 32'hBEEF8000, 0, 0);
    req(0, 32'h22, 32'h0, 3'b001, 32'hFFFFBEEF, 0, 0);
    req(0, 32'h22, 32'h0, 3'b101, 32'h0000BEEF, 0, 0);
    req(1, 32'h20, 32'hFF, 3'b100, 32'h0, 1, 0);
    req(1, 32'h21, 32'hFFFF, 3'b001, 32'h0, 1, 0);
    req(0, 32'h20, 32'h0, 3'b011, 32'h0, 1, 0);
    req(0, 32'h20, 32'h0, 3'b010, 32'hBEEF8000, 0, 0);
`else
    req(1, 32'h41, 32'h11223344, 3'b000, 32'h0, 0, 0);
    req(0, 32'h40, 32'h0, 3'b010, 32'h11223344, 0, 0);
    req(0, 32'h43, 32'h0, 3'b000, 32'h11223344, 0, 0);
    req(0, 32'h10, 32'h0, 3'b111, 32'hDEADBEEF, 0, 0);
`endif

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
